// File: rtl/mem_port_arbiter_if.sv
// Bundle for the shared memory port.
// "slave" is the arbiter's view: requester and memory inputs come in, strobes and responses go out.
// "master" is the other side: the requesters plus the physical memory.
interface mem_port_arbiter_if;
    // I-side: instruction fetch, read-only
    logic        i_read;
    logic [15:0] i_address;
    logic        i_resp;
    logic [15:0] i_rdata;

    // D-side: load/store, with byte lanes
    logic        d_read;
    logic        d_write;
    logic [15:0] d_address;
    logic [15:0] d_wdata;
    logic [1:0]  d_byte_enable;
    logic        d_resp;
    logic [15:0] d_rdata;

    // Physical memory port
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [1:0]  pmem_byte_enable;
    logic        pmem_resp;
    logic [15:0] pmem_rdata;

    logic        busy;

    modport slave (
        input  i_read, i_address,
        input  d_read, d_write, d_address, d_wdata, d_byte_enable,
        input  pmem_resp, pmem_rdata,
        output i_resp, i_rdata, d_resp, d_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
        output busy
    );

    modport master (
        output i_read, i_address,
        output d_read, d_write, d_address, d_wdata, d_byte_enable,
        output pmem_resp, pmem_rdata,
        input  i_resp, i_rdata, d_resp, d_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter that lets I-fetch and load/store share one physical memory port.
// Only one transaction is in flight at a time, and D-side has priority.
// A streak counter limits how long I-side can be starved: after D_MAX_CONSEC
// D grants in a row while I was waiting, the next grant goes to I.
module mem_port_arbiter #(
    parameter int D_MAX_CONSEC = 4   // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    // Everything presented on the physical port, captured at grant time
    typedef struct packed {
        logic        read;
        logic        write;
        logic [15:0] address;
        logic [15:0] wdata;
        logic [1:0]  byte_enable;
    } pmem_req_t;

    localparam logic [3:0] STREAK_MAX = 4'(D_MAX_CONSEC);

    state_t    state, state_nxt;
    pmem_req_t req_q, req_nxt;
    logic [3:0] d_streak, d_streak_nxt;
    logic       busy_q, busy_nxt;
    logic       i_pend, d_pend;

    assign i_pend = bus.i_read;
    assign d_pend = bus.d_read | bus.d_write;

    // State, latched port request, streak counter and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            req_q    <= '0;
            d_streak <= 4'd0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            req_q    <= req_nxt;
            d_streak <= d_streak_nxt;
            busy_q   <= busy_nxt;
        end
    end

    // Arbitration in IDLE, grant latch, and return to IDLE on completion
    always_comb begin
        state_nxt    = state;
        req_nxt      = req_q;
        d_streak_nxt = d_streak;
        busy_nxt     = busy_q;
        unique case (state)
            IDLE: begin
                // D wins unless I has been held off for the full streak
                if (d_pend && !(i_pend && d_streak >= STREAK_MAX)) begin
                    state_nxt           = SERVE_D;
                    busy_nxt            = 1'b1;
                    // a write takes precedence if both strobes are raised together
                    req_nxt.write       = bus.d_write;
                    req_nxt.read        = ~bus.d_write;
                    req_nxt.address     = bus.d_address;
                    req_nxt.wdata       = bus.d_wdata;
                    req_nxt.byte_enable = bus.d_byte_enable;
                    if (!i_pend)
                        d_streak_nxt = 4'd0;
                    else if (d_streak < STREAK_MAX)
                        d_streak_nxt = d_streak + 4'd1;
                end else if (i_pend) begin
                    state_nxt           = SERVE_I;
                    busy_nxt            = 1'b1;
                    req_nxt.read        = 1'b1;
                    req_nxt.write       = 1'b0;
                    req_nxt.address     = bus.i_address;
                    req_nxt.wdata       = bus.d_wdata;
                    req_nxt.byte_enable = 2'b11;
                    d_streak_nxt        = 4'd0;
                end
            end
            SERVE_I, SERVE_D: begin
                if (bus.pmem_resp) begin
                    state_nxt     = IDLE;
                    req_nxt.read  = 1'b0;
                    req_nxt.write = 1'b0;
                    busy_nxt      = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.pmem_read        = req_q.read;
    assign bus.pmem_write       = req_q.write;
    assign bus.pmem_address     = req_q.address;
    assign bus.pmem_wdata       = req_q.wdata;
    assign bus.pmem_byte_enable = req_q.byte_enable;
    assign bus.busy             = busy_q;

    // Responses are combinational off the memory completion; data is shared
    assign bus.i_resp  = bus.pmem_resp & (state == SERVE_I);
    assign bus.d_resp  = bus.pmem_resp & (state == SERVE_D);
    assign bus.i_rdata = bus.pmem_rdata;
    assign bus.d_rdata = bus.pmem_rdata;

endmodule
